// File: rtl/fp_pkg.sv
// Shared FP32 types, constants and FSM encoding for the accumulator.
// Pure definitions; no logic, no latency, no flow control.
package fp_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MANT_W   = 24;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ALIGN,
    ST_ADD,
    ST_NORM,
    ST_OUT
  } state_t;

  // Zero and denormal operands contribute nothing, whatever their fraction bits.
  function automatic logic [MANT_W-1:0] mant_of(input fp32_t f);
    return (f.exp == 8'd0) ? '0 : {1'b1, f.frac};
  endfunction

endpackage

// File: rtl/lzc24.sv
// Combinational leading-zero count of a 24-bit word; 24 when the word is all zero.
// Zero latency, no flow control.
module lzc24 (
  input  logic [23:0] data_i,
  output logic [4:0]  count_o
);

  always_comb begin
    count_o = 5'd24;
    // Scanning upward lets the most significant set bit win.
    for (int i = 0; i < 24; i++) begin
      if (data_i[i]) count_o = 5'(23 - i);
    end
  end

endmodule

// File: rtl/fp_accum.sv
// FP32 truncating accumulator: IDLE -> ALIGN -> ADD -> NORM, one term per 4 cycles.
// in_ready only in IDLE; a finished sum is held in OUT until out_ready.
module fp_accum
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        busy
);

  state_t             state_q, state_d;
  fp32_t              acc_q, acc_d;
  fp32_t              term_q, term_d;
  logic               last_q, last_d;
  logic               a_sign_q, a_sign_d;
  logic [7:0]         a_exp_q, a_exp_d;
  logic [MANT_W-1:0]  a_mant_q, a_mant_d;
  logic [MANT_W-1:0]  b_mant_q, b_mant_d;
  logic               sub_q, sub_d;
  logic               inf_q, inf_d;
  logic               inf_sign_q, inf_sign_d;
  logic [MANT_W:0]    sum_q, sum_d;

  // Alignment of the accumulator against the captured term.
  logic [MANT_W-1:0]  mx, my, small_mant, shifted;
  logic [7:0]         ex, ey, diff;
  logic               x_big;

  always_comb begin
    mx    = mant_of(acc_q);
    my    = mant_of(term_q);
    ex    = (acc_q.exp  == 8'd0) ? 8'd0 : acc_q.exp;
    ey    = (term_q.exp == 8'd0) ? 8'd0 : term_q.exp;
    x_big = {ex, mx} >= {ey, my};
    diff       = x_big ? (ex - ey) : (ey - ex);
    small_mant = x_big ? my : mx;
    shifted    = (diff >= 8'd25) ? '0 : (small_mant >> diff);
  end

  // Normalisation of the registered sum.
  logic [4:0]         lz;
  logic [MANT_W-1:0]  mant_n;
  logic signed [9:0]  exp_n;
  fp32_t              norm_res;

  lzc24 u_lzc (
    .data_i  (sum_q[MANT_W-1:0]),
    .count_o (lz)
  );

  always_comb begin
    if (sum_q[MANT_W]) begin
      mant_n = sum_q[MANT_W:1];
      exp_n  = $signed({2'b00, a_exp_q}) + 10'sd1;
    end else begin
      mant_n = sum_q[MANT_W-1:0] << lz;
      exp_n  = $signed({2'b00, a_exp_q}) - $signed({5'b00000, lz});
    end

    if (inf_q)
      norm_res = '{sign: inf_sign_q, exp: 8'(EXP_MAX), frac: 23'd0};
    else if (mant_n == '0)
      norm_res = '0;
    else if (exp_n <= 10'sd0)
      norm_res = '{sign: a_sign_q, exp: 8'd0, frac: 23'd0};
    else if (exp_n >= 10'sd255)
      norm_res = '{sign: a_sign_q, exp: 8'(EXP_MAX), frac: 23'd0};
    else
      norm_res = '{sign: a_sign_q, exp: exp_n[7:0], frac: mant_n[22:0]};
  end

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    term_d     = term_q;
    last_d     = last_q;
    a_sign_d   = a_sign_q;
    a_exp_d    = a_exp_q;
    a_mant_d   = a_mant_q;
    b_mant_d   = b_mant_q;
    sub_d      = sub_q;
    inf_d      = inf_q;
    inf_sign_d = inf_sign_q;
    sum_d      = sum_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          term_d  = in_data;
          last_d  = in_last;
          state_d = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        a_sign_d   = x_big ? acc_q.sign : term_q.sign;
        a_exp_d    = x_big ? ex : ey;
        a_mant_d   = x_big ? mx : my;
        b_mant_d   = shifted;
        sub_d      = acc_q.sign ^ term_q.sign;
        // An infinite term takes its own sign; a saturated accumulator stays infinite.
        inf_d      = (term_q.exp == 8'(EXP_MAX)) || (acc_q.exp == 8'(EXP_MAX));
        inf_sign_d = (term_q.exp == 8'(EXP_MAX)) ? term_q.sign : acc_q.sign;
        state_d    = ST_ADD;
      end
      ST_ADD: begin
        sum_d   = sub_q ? ({1'b0, a_mant_q} - {1'b0, b_mant_q})
                        : ({1'b0, a_mant_q} + {1'b0, b_mant_q});
        state_d = ST_NORM;
      end
      ST_NORM: begin
        acc_d   = norm_res;
        state_d = last_q ? ST_OUT : ST_IDLE;
      end
      ST_OUT: begin
        if (out_ready) begin
          acc_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      term_q     <= '0;
      last_q     <= 1'b0;
      a_sign_q   <= 1'b0;
      a_exp_q    <= '0;
      a_mant_q   <= '0;
      b_mant_q   <= '0;
      sub_q      <= 1'b0;
      inf_q      <= 1'b0;
      inf_sign_q <= 1'b0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      term_q     <= term_d;
      last_q     <= last_d;
      a_sign_q   <= a_sign_d;
      a_exp_q    <= a_exp_d;
      a_mant_q   <= a_mant_d;
      b_mant_q   <= b_mant_d;
      sub_q      <= sub_d;
      inf_q      <= inf_d;
      inf_sign_q <= inf_sign_d;
      sum_q      <= sum_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_OUT);
  assign out_data  = (state_q == ST_OUT) ? acc_q : 32'd0;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fp_accum.sv
// Scoreboard bench for fp_accum: expected sums queued at stimulus, checked on output.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_fp_accum;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];

  fp_accum dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
    end
  endtask

  // Returns #1 after the edge at which the term was accepted.
  task automatic accept(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [31:0] want);
    accept(d, l);
    if (l) exp_q.push_back(want);
    repeat (3) @(posedge clk);
    #1;
    if (l) chk("lat_out_valid", 32'(out_valid), 32'd1);
    else   chk("lat_in_ready", 32'(in_ready), 32'd1);
  endtask

  task automatic collect(input int stall);
    logic [31:0] want;
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
    if (exp_q.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
      want = 32'hxxxxxxxx;
    end else begin
      want = exp_q.pop_front();
    end
    for (int i = 0; i < stall; i++) begin
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_out_data", out_data, want);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk("out_data", out_data, want);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_out_valid", 32'(out_valid), 32'd0);
    chk("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    send(32'h3F800000, 1'b0, 32'h0);
    send(32'h40000000, 1'b1, 32'h40400000);
    collect(0);

    send(32'h3F800000, 1'b0, 32'h0);
    send(32'hBF800000, 1'b1, 32'h00000000);
    collect(0);

    send(32'h7F000000, 1'b0, 32'h0);
    send(32'h7F000000, 1'b1, 32'h7F800000);
    collect(0);

    out_ready = 1'b0;
    send(32'h3FC00000, 1'b0, 32'h0);
    send(32'h3E800000, 1'b1, 32'h3FE00000);
    collect(5);
    send(32'h40000000, 1'b1, 32'h40000000);
    collect(0);

    send(32'h4B800000, 1'b0, 32'h0);
    send(32'h3F800000, 1'b1, 32'h4B800000);
    collect(0);

    send(32'hC0000000, 1'b0, 32'h0);
    send(32'h3F800000, 1'b1, 32'hBF800000);
    collect(0);

    send(32'h00000001, 1'b0, 32'h0);
    send(32'h40000000, 1'b1, 32'h40000000);
    collect(0);

    send(32'hFF800000, 1'b1, 32'hFF800000);
    collect(0);

    send(32'h00800000, 1'b0, 32'h0);
    send(32'h80C00000, 1'b1, 32'h80000000);
    collect(0);

    // Reset lands while the second term is in ADD.
    send(32'h3F800000, 1'b0, 32'h0);
    accept(32'h40000000, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_output", 32'(out_valid), 32'd0);
    send(32'h40000000, 1'b1, 32'h40000000);
    collect(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fp_accum.md
FP_ACCUM -- requirements
Module: fp_accum

Interface
REQ-001 Parameters SHALL be: none; all widths are fixed to IEEE-754 single precision (32-bit).
REQ-002 clk  input  1  rising-edge clock; the only clock.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in_valid  input  1  in_data/in_last hold a term to accumulate.
REQ-005 in_ready  output  1  block can accept a term this cycle.
REQ-006 in_data  input  32  FP32 term (sign[31], exp[30:23], frac[22:0]), typically a multiplier product.
REQ-007 in_last  input  1  marks the final term of a sum.
REQ-008 out_valid  output  1  out_data holds a completed sum.
REQ-009 out_ready  input  1  consumer accepts out_data.
REQ-010 out_data  output  32  FP32 accumulated sum.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states SHALL be IDLE, ALIGN, ADD, NORM, OUT.
REQ-013 in_ready SHALL be 1 only in IDLE; a term is accepted at a rising edge with in_valid && in_ready, captured with in_last, and the FSM moves to ALIGN.
REQ-014 The sequence ALIGN -> ADD -> NORM SHALL take exactly one cycle per state; from NORM the FSM goes to OUT if the captured in_last=1, else to IDLE.
REQ-015 Term accepted at edge T: in_ready or out_valid SHALL be high in cycle T+4; throughput is 1 term per 4 cycles.
REQ-016 OUT: out_valid=1 and out_data=accumulator, both stable until out_valid && out_ready; on that edge the accumulator clears to +0 and the FSM returns to IDLE.
REQ-017 Any operand with exp==0 (zero or denormal) SHALL be treated as zero, with frac ignored.
REQ-018 ALIGN: the operand with the larger exponent is A; ties are broken by the larger mantissa.
REQ-019 ALIGN: B's 24-bit mantissa (hidden 1 included) shifts right by the exponent difference; a difference >= 25 yields B=0.
REQ-020 ADD: equal signs add mantissas into a 25-bit result; unequal signs compute A-B. The result sign is A's sign.
REQ-021 NORM, carry case: if bit 24 is set, shift right 1 and add 1 to the exponent.
REQ-022 NORM, leading zeros: shift left by the leading-zero count of the 24-bit result and subtract that count from the exponent.
REQ-023 Rounding SHALL be truncation: discarded bits are dropped.
REQ-024 A zero mantissa result SHALL give +0 (0x00000000).
REQ-025 A result exponent <= 0 SHALL flush to signed zero.
REQ-026 A result exponent >= 255 SHALL saturate to signed infinity (exp=255, frac=0).
REQ-027 Input exp==255 (inf/NaN) SHALL produce signed infinity with sign = input sign; there is no NaN propagation.
REQ-028 in_valid is ignored outside IDLE; no term is lost, because the source must hold in_valid until in_ready.

Reset
REQ-029 When rst=1 at a rising edge: FSM->IDLE, accumulator=+0, in_ready=1, out_valid=0, out_data=0, busy=0.
REQ-030 Reset mid-operation SHALL abandon the partial sum and the in-flight term with no output produced; reset wins over a simultaneous handshake.

Structure
REQ-031 Shared package fp_pkg SHALL hold: EXP_BIAS=127, EXP_MAX=255, MANT_W=24, the fp32 packed struct typedef, and the FSM state enum typedef.
REQ-032 A sub-module lzc24 SHALL implement the combinational 24-bit leading-zero count (5-bit output, 24 for all-zero).
REQ-033 All state SHALL be held in a single clocked process with synchronous reset; the datapath between registers is combinational.

Verification
REQ-034 Sum: 0x3F800000 (last=0), then 0x40000000 (last=1), out_ready=1 -> out_data=0x40400000, out_valid in cycle T2+4.
REQ-035 Cancellation: 0x3F800000 then 0xBF800000 (last) -> 0x00000000.
REQ-036 Overflow: 0x7F000000 then 0x7F000000 (last) -> 0x7F800000.
REQ-037 Backpressure: out_ready=0 for 5 cycles -> out_valid and out_data stable and in_ready=0 throughout; accumulator is +0 after the handshake.
REQ-038 Alignment: 0x4B800000 (2^24) plus 0x3F800000 (last) -> 0x4B800000, since the 1.0 term is lost to truncation.
REQ-039 Reset: rst asserted during ADD of the second term -> next cycle IDLE with out_valid=0; a following sum of 0x40000000 (last) alone -> 0x40000000.
